// File: rtl/load_store_unit_if.sv
// CPU-side request/response and memory-bus signals of the load/store unit.
// The slave modport is the unit; the master modport is the CPU/bus side.
interface load_store_unit_if;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [15:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] bus_address;
  logic [31:0] bus_data_out;
  logic [31:0] bus_data_in;
  logic [3:0]  bus_write_mask;
  logic        bus_enable;
  logic        bus_write_enable;

  modport slave (
    input  start, is_store, funct3, address, store_data, bus_data_in,
    output load_data, busy, done, error, bus_address, bus_data_out,
    output bus_write_mask, bus_enable, bus_write_enable
  );

  modport master (
    output start, is_store, funct3, address, store_data, bus_data_in,
    input  load_data, busy, done, error, bus_address, bus_data_out,
    input  bus_write_mask, bus_enable, bus_write_enable
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V byte/half/word load-store unit driving a word-wide memory bus.
// Define MISALIGN_TRAP_EN to reject misaligned accesses instead of truncating.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  lsu
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_is_store;
  logic [1:0]  r_cnt;
  logic [31:0] r_load_data;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_bus_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_bus_en;
  logic        r_bus_we;

  logic        w_legal;
  logic        w_reject;
  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  // Request decode: legality, aligned lane offset, store mask and data.
  always_comb begin
    w_legal = 1'b0;
    w_off   = 2'b00;
    w_mask  = 4'b1111;
    w_wdata = lsu.store_data;
    case (lsu.funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101: w_legal = !lsu.is_store;
      default: w_legal = 1'b0;
    endcase
    case (lsu.funct3[1:0])
      2'b00: begin
        w_off   = lsu.address[1:0];
        w_mask  = 4'b0001 << lsu.address[1:0];
        w_wdata = {4{lsu.store_data[7:0]}};
      end
      2'b01: begin
        w_off   = {lsu.address[1], 1'b0};
        w_mask  = lsu.address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{lsu.store_data[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_mask  = 4'b1111;
        w_wdata = lsu.store_data;
      end
    endcase
`ifdef MISALIGN_TRAP_EN
    case (lsu.funct3[1:0])
      2'b01:   w_reject = !w_legal || lsu.address[0];
      2'b10:   w_reject = !w_legal || (lsu.address[1:0] != 2'b00);
      default: w_reject = !w_legal;
    endcase
`else
    w_reject = !w_legal;
`endif
  end

  // Load lane select and sign/zero extension of the returned bus word.
  always_comb begin
    w_lane = lsu.bus_data_in >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {24'd0, w_lane[7:0]};
      3'b101:  w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = lsu.bus_data_in;
    endcase
  end

  // Request sequencer with registered CPU and bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_is_store  <= 1'b0;
      r_cnt       <= 2'd0;
      r_load_data <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_bus_addr  <= 16'd0;
      r_wdata     <= 32'd0;
      r_mask      <= 4'd0;
      r_bus_en    <= 1'b0;
      r_bus_we    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          if (lsu.start) begin
            r_funct3   <= lsu.funct3;
            r_off      <= w_off;
            r_is_store <= lsu.is_store;
            if (w_reject) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_busy     <= 1'b1;
              r_bus_en   <= 1'b1;
              r_bus_addr <= {lsu.address[15:2], 2'b00};
              r_bus_we   <= lsu.is_store;
              r_mask     <= lsu.is_store ? w_mask : 4'd0;
              r_wdata    <= lsu.is_store ? w_wdata : 32'd0;
            end
          end
        end
        S_ISSUE: begin
          r_bus_en <= 1'b0;
          r_bus_we <= 1'b0;
          r_mask   <= 4'd0;
          r_wdata  <= 32'd0;
          r_cnt    <= 2'(READ_LATENCY - 1);
          if (r_is_store) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_load_data <= w_ext;
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lsu.load_data        = r_load_data;
  assign lsu.busy             = r_busy;
  assign lsu.done             = r_done;
  assign lsu.error            = r_error;
  assign lsu.bus_address      = r_bus_addr;
  assign lsu.bus_data_out     = r_wdata;
  assign lsu.bus_write_mask   = r_mask;
  assign lsu.bus_enable       = r_bus_en;
  assign lsu.bus_write_enable = r_bus_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-level reference model.
// Honours MISALIGN_TRAP_EN when the bench is built with it.
module tb_load_store_unit;

  localparam int RL = 1;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.READ_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          o_done_cyc, o_done_cnt, o_en_cnt, o_we_cnt, o_mask_cnt;
  logic        o_err;
  logic [31:0] o_ld, o_bdata;
  logic [15:0] o_baddr;
  logic [3:0]  o_mask;

  int          e_dc, e_en;
  logic        e_err;
  logic [31:0] e_ld, e_bd;
  logic [3:0]  e_mk;
  logic [15:0] e_ba;

  // Reference model: byte-level arithmetic from the ISA rules.
  task automatic model(input logic st, input logic [2:0] f3,
                       input logic [15:0] a, input logic [31:0] sd,
                       input logic [31:0] bdi);
    int size, off, lo;
    bit legal, mis, trap;
    longint m, v;
    legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    size  = 1 << f3[1:0];
    if (size > 4) size = 4;
    lo    = int'(a) % 4;
    mis   = (lo % size) != 0;
    trap  = !legal || (TRAP && mis);
    off   = lo - (lo % size);
    e_err = trap;
    e_dc  = trap ? 1 : (st ? 2 : 2 + RL);
    e_en  = trap ? 0 : 1;
    e_ba  = a - 16'(lo);
    e_mk  = st ? 4'(((1 << size) - 1) << off) : 4'd0;
    if (size == 1) e_bd = sd[7:0] * 32'h01010101;
    else if (size == 2) e_bd = sd[15:0] * 32'h00010001;
    else e_bd = sd;
    m = 64'd1 << (8 * size);
    v = (longint'(bdi) >> (8 * off)) % m;
    if (!f3[2] && size < 4 && v >= m / 2) v = v - m;
    e_ld = v[31:0];
  endtask

  // Issue one request and record what the DUT does over the next cycles.
  task automatic run_req(input logic st, input logic [2:0] f3,
                         input logic [15:0] a, input logic [31:0] sd,
                         input logic [31:0] bdi, input int restart_at);
    o_done_cyc = 0; o_done_cnt = 0; o_en_cnt = 0;
    o_we_cnt = 0; o_mask_cnt = 0; o_err = 1'b0;
    o_ld = '0; o_bdata = '0; o_baddr = '0; o_mask = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3;
    bus.address = a; bus.store_data = sd; bus.bus_data_in = bdi;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.done) begin
        o_done_cnt++;
        if (o_done_cnt == 1) begin
          o_done_cyc = k; o_err = bus.error; o_ld = bus.load_data;
        end
      end
      if (bus.bus_enable) begin
        o_en_cnt++;
        if (o_en_cnt == 1) begin
          o_baddr = bus.bus_address; o_mask = bus.bus_write_mask;
          o_bdata = bus.bus_data_out;
        end
      end
      if (bus.bus_write_enable) o_we_cnt++;
      if (bus.bus_write_mask != 4'd0) o_mask_cnt++;
      if (k == restart_at) begin
        bus.start = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b011;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.error, bus.bus_enable,
         bus.bus_write_enable} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctl got %b want 00000", {bus.busy, bus.done,
               bus.error, bus.bus_enable, bus.bus_write_enable});
    end
    n_checks++;
    if ({bus.load_data, bus.bus_address, bus.bus_data_out,
         bus.bus_write_mask} !== 84'd0) begin
      n_errors++;
      $display("FAIL reset_data got %h want 0", {bus.load_data,
               bus.bus_address, bus.bus_data_out, bus.bus_write_mask});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_store_sb;
    run_req(1'b1, 3'b000, 16'h4002, 32'h000000A5, 32'h0, 0);
    n_checks++;
    if (o_baddr !== 16'h4000) begin
      n_errors++; $display("FAIL sb_addr got %h want 4000", o_baddr);
    end
    n_checks++;
    if (o_mask !== 4'b0100) begin
      n_errors++; $display("FAIL sb_mask got %b want 0100", o_mask);
    end
    n_checks++;
    if (o_bdata !== 32'hA5A5A5A5) begin
      n_errors++; $display("FAIL sb_data got %h want A5A5A5A5", o_bdata);
    end
    n_checks++;
    if (o_done_cyc !== 2 || o_err !== 1'b0) begin
      n_errors++;
      $display("FAIL sb_done got cyc %0d err %b want 2 0", o_done_cyc, o_err);
    end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [15:0] as  [4] = '{16'h0003, 16'h0003, 16'h0002, 16'h0002};
    logic [31:0] ds  [4] = '{32'h80FF7F01, 32'h80FF7F01,
                             32'h8001ABCD, 32'h8001ABCD};
    logic [31:0] xs  [4] = '{32'hFFFFFF80, 32'h00000080,
                             32'hFFFF8001, 32'h00008001};
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, f3s[i], as[i], 32'h0, ds[i], 0);
      n_checks++;
      if (o_ld !== xs[i] || o_done_cyc !== 2 + RL) begin
        n_errors++;
        $display("FAIL load_ext%0d got %h cyc %0d want %h cyc %0d",
                 i, o_ld, o_done_cyc, xs[i], 2 + RL);
      end
    end
  endtask

  task automatic test_misalign_lw;
    run_req(1'b0, 3'b010, 16'h0001, 32'h0, 32'hCAFEF00D, 0);
    n_checks++;
    if (TRAP) begin
      if (o_done_cyc !== 1 || o_err !== 1'b1 || o_en_cnt !== 0) begin
        n_errors++;
        $display("FAIL lw_mis got cyc %0d err %b en %0d want 1 1 0",
                 o_done_cyc, o_err, o_en_cnt);
      end
    end else begin
      if (o_baddr !== 16'h0 || o_ld !== 32'hCAFEF00D || o_err !== 1'b0) begin
        n_errors++;
        $display("FAIL lw_mis got addr %h ld %h err %b want 0000 cafef00d 0",
                 o_baddr, o_ld, o_err);
      end
    end
  endtask

  task automatic test_illegal;
    run_req(1'b0, 3'b011, 16'h0010, 32'h0, 32'h12345678, 0);
    n_checks++;
    if (o_done_cyc !== 1 || o_err !== 1'b1 || o_en_cnt !== 0) begin
      n_errors++;
      $display("FAIL illegal got cyc %0d err %b en %0d want 1 1 0",
               o_done_cyc, o_err, o_en_cnt);
    end
  endtask

  task automatic test_busy_ignore;
    for (int r = 1; r <= 2; r++) begin
      run_req(1'b1, 3'b010, 16'h0008, 32'h11223344, 32'h0, r);
      n_checks++;
      if (o_done_cnt !== 1 || o_err !== 1'b0 || o_done_cyc !== 2) begin
        n_errors++;
        $display("FAIL ignore%0d got dones %0d err %b cyc %0d want 1 0 2",
                 r, o_done_cnt, o_err, o_done_cyc);
      end
    end
  endtask

  task automatic test_reset_mid_issue;
    int dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b010;
    bus.address = 16'h0020; bus.store_data = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.bus_write_enable !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_pre_we got %b want 1", bus.bus_write_enable);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.bus_write_enable, bus.busy, bus.bus_enable,
         bus.bus_write_mask} !== 7'b0) begin
      n_errors++;
      $display("FAIL rst_abort got %b want 0", {bus.bus_write_enable,
               bus.busy, bus.bus_enable, bus.bus_write_mask});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 0) begin
      n_errors++; $display("FAIL rst_no_done got %0d want 0", dones);
    end
  endtask

  task automatic test_random;
    logic st;
    logic [2:0] f3;
    logic [15:0] a;
    logic [31:0] sd, bdi;
    for (int i = 0; i < 60; i++) begin
      st  = 1'($urandom);
      f3  = 3'($urandom);
      a   = 16'($urandom);
      sd  = $urandom;
      bdi = $urandom;
      model(st, f3, a, sd, bdi);
      run_req(st, f3, a, sd, bdi, 0);
      n_checks++;
      if (o_done_cyc !== e_dc || o_done_cnt !== 1 || o_err !== e_err) begin
        n_errors++;
        $display("FAIL rnd%0d_done got cyc %0d n %0d err %b want %0d 1 %b",
                 i, o_done_cyc, o_done_cnt, o_err, e_dc, e_err);
      end
      n_checks++;
      if (o_en_cnt !== e_en || o_we_cnt !== int'(st && !e_err)
          || o_mask_cnt !== int'(st && !e_err)) begin
        n_errors++;
        $display("FAIL rnd%0d_bus got en %0d we %0d mk %0d want %0d %0d",
                 i, o_en_cnt, o_we_cnt, o_mask_cnt, e_en,
                 int'(st && !e_err));
      end
      if (!e_err) begin
        n_checks++;
        if (o_baddr !== e_ba || o_mask !== e_mk
            || (st && o_bdata !== e_bd)) begin
          n_errors++;
          $display("FAIL rnd%0d_issue got %h %b %h want %h %b %h",
                   i, o_baddr, o_mask, o_bdata, e_ba, e_mk, e_bd);
        end
      end
      if (!st && !e_err) begin
        n_checks++;
        if (o_ld !== e_ld) begin
          n_errors++;
          $display("FAIL rnd%0d_load f3 %b a %h got %h want %h",
                   i, f3, a, o_ld, e_ld);
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'd0;
    bus.address = 16'd0; bus.store_data = 32'd0; bus.bus_data_in = 32'd0;
    test_reset();
    test_store_sb();
    test_load_ext();
    test_misalign_lw();
    test_illegal();
    test_busy_ignore();
    test_reset_mid_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
